// File: rtl/ascon_pkg.sv
// Ascon-Hash256 sequencer constants and state encoding.
// Shared by the controller, its padding helper and the stream interface users.
package ascon_pkg;

  localparam logic [63:0] ASCON_HASH256_IV = 64'h0000080100CC0002;
  localparam int ASCON_PA_ROUNDS = 12;
  localparam int RATE_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PERM,
    ABSORB,
    PAD,
    SQUEEZE
  } hash_state_t;

endpackage

// File: rtl/ascon_hash_ctrl_if.sv
// Message-in and digest-out valid/ready streams of the hash sequencer.
// master = host side, slave = ascon_hash_ctrl.
interface ascon_hash_ctrl_if;

  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_bytes;
  logic        in_last;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, in_bytes, in_last,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_bytes, in_last,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_last
  );

endinterface

// File: rtl/ascon_pad64.sv
// Keeps bytes below n, inserts 8'h01 at byte n and zeroes the rest.
// n >= 8 passes the word through unchanged.
module ascon_pad64
  import ascon_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [3:0]  i_n,
  output logic [63:0] o_data
);

  always_comb begin
    o_data = '0;
    for (int k = 0; k < RATE_BYTES; k++) begin
      if (k < int'(i_n))
        o_data[8*k +: 8] = i_data[8*k +: 8];
      else if (k == int'(i_n))
        o_data[8*k +: 8] = 8'h01;
    end
  end

endmodule

// File: rtl/ascon_hash_ctrl.sv
// Ascon-Hash256 sequencer: drives asconp load/round controls,
// absorbs a 64-bit LE message stream and squeezes a 256-bit digest.
module ascon_hash_ctrl
  import ascon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  ascon_hash_ctrl_if.slave bus,
  output logic        load_val,
  output logic [63:0] S_0_load_val,
  output logic [63:0] S_1_load_val,
  output logic [63:0] S_2_load_val,
  output logic [63:0] S_3_load_val,
  output logic [63:0] S_4_load_val,
  output logic [3:0]  num_rounds,
  output logic        rounds_enable,
  output logic [3:0]  round_ctr,
  input  logic [63:0] S_0_reg,
  input  logic [63:0] S_1_reg,
  input  logic [63:0] S_2_reg,
  input  logic [63:0] S_3_reg,
  input  logic [63:0] S_4_reg
);

  localparam logic [3:0] LAST_RND = 4'(ASCON_PA_ROUNDS - 1);
  localparam logic [3:0] FULL_N   = 4'(RATE_BYTES);

  hash_state_t r_state;
  hash_state_t r_ret;
  logic [3:0]  r_round_ctr;
  logic [1:0]  r_word_cnt;
  logic        r_done;

  logic [3:0]  w_n;
  logic [63:0] w_pad;
  logic [63:0] w_blk;
  logic        w_full;
  logic        w_in_hs;

  // in_bytes 9..15 behaves as a full word
  assign w_n     = (bus.in_bytes > FULL_N) ? FULL_N : bus.in_bytes;
  assign w_full  = (w_n == FULL_N);
  assign w_blk   = bus.in_last ? w_pad : bus.in_data;
  assign w_in_hs = (r_state == ABSORB) && bus.in_valid;

  ascon_pad64 u_pad (
    .i_data (bus.in_data),
    .i_n    (w_n),
    .o_data (w_pad)
  );

  assign busy          = (r_state != IDLE);
  assign bus.in_ready  = (r_state == ABSORB);
  assign bus.out_valid = (r_state == SQUEEZE);
  assign bus.out_data  = bus.out_valid ? S_0_reg : '0;
  assign bus.out_last  = bus.out_valid && (r_word_cnt == 2'd3);
  assign rounds_enable = (r_state == PERM);
  assign round_ctr     = r_round_ctr;
  assign num_rounds    = 4'(ASCON_PA_ROUNDS);
  assign done          = r_done;

  always_comb begin
    load_val     = 1'b0;
    S_0_load_val = S_0_reg;
    S_1_load_val = S_1_reg;
    S_2_load_val = S_2_reg;
    S_3_load_val = S_3_reg;
    S_4_load_val = S_4_reg;
    unique case (1'b1)
      (r_state == INIT): begin
        load_val     = 1'b1;
        S_0_load_val = ASCON_HASH256_IV;
        S_1_load_val = '0;
        S_2_load_val = '0;
        S_3_load_val = '0;
        S_4_load_val = '0;
      end
      w_in_hs: begin
        load_val     = 1'b1;
        S_0_load_val = S_0_reg ^ w_blk;
      end
      (r_state == PAD): begin
        load_val     = 1'b1;
        S_0_load_val = S_0_reg ^ 64'h1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ret       <= ABSORB;
      r_round_ctr <= '0;
      r_word_cnt  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE:
          if (start) r_state <= INIT;
        INIT: begin
          r_ret   <= ABSORB;
          r_state <= PERM;
        end
        PERM:
          if (r_round_ctr == LAST_RND) begin
            r_round_ctr <= '0;
            r_state     <= r_ret;
          end else begin
            r_round_ctr <= r_round_ctr + 4'd1;
          end
        ABSORB:
          if (bus.in_valid) begin
            r_state <= PERM;
            r_ret   <= !bus.in_last ? ABSORB :
                       w_full       ? PAD    : SQUEEZE;
          end
        PAD: begin
          r_ret   <= SQUEEZE;
          r_state <= PERM;
        end
        SQUEEZE:
          if (bus.out_ready) begin
            if (r_word_cnt == 2'd3) begin
              r_done     <= 1'b1;
              r_word_cnt <= '0;
              r_state    <= IDLE;
            end else begin
              r_word_cnt <= r_word_cnt + 2'd1;
              r_ret      <= SQUEEZE;
              r_state    <= PERM;
            end
          end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_hash_ctrl.sv
// Bench for ascon_hash_ctrl: behavioural asconp plus a software
// Ascon-Hash256 reference feeding a digest scoreboard.
module tb_ascon_hash_ctrl;

  typedef logic [4:0][63:0] st_t;
  typedef struct {
    logic [63:0] w;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, load_val, rounds_enable;
  logic [3:0] num_rounds, round_ctr;
  logic [63:0] ld0, ld1, ld2, ld3, ld4;
  st_t m_s;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ascon_hash_ctrl_if bus ();

  ascon_hash_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .bus           (bus),
    .load_val      (load_val),
    .S_0_load_val  (ld0),
    .S_1_load_val  (ld1),
    .S_2_load_val  (ld2),
    .S_3_load_val  (ld3),
    .S_4_load_val  (ld4),
    .num_rounds    (num_rounds),
    .rounds_enable (rounds_enable),
    .round_ctr     (round_ctr),
    .S_0_reg       (m_s[0]),
    .S_1_reg       (m_s[1]),
    .S_2_reg       (m_s[2]),
    .S_3_reg       (m_s[3]),
    .S_4_reg       (m_s[4])
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x,
                                      input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t rnd(input st_t s, input int r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 ^= {56'h0, 8'(((15 - r) << 4) | r)};
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3;
    t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 ^= ror(x0, 19) ^ ror(x0, 28);
    x1 ^= ror(x1, 61) ^ ror(x1, 39);
    x2 ^= ror(x2, 1) ^ ror(x2, 6);
    x3 ^= ror(x3, 10) ^ ror(x3, 17);
    x4 ^= ror(x4, 7) ^ ror(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  function automatic st_t p12(input st_t s);
    st_t t;
    t = s;
    for (int r = 0; r < 12; r++) t = rnd(t, r);
    return t;
  endfunction

  function automatic logic [63:0] pad_ref(input logic [63:0] d,
                                          input int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < n) r[8*k +: 8] = d[8*k +: 8];
      else if (k == n) r[8*k +: 8] = 8'h01;
    end
    return r;
  endfunction

  // asconp stand-in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_s <= '0;
    else if (load_val) m_s <= {ld4, ld3, ld2, ld1, ld0};
    else if (rounds_enable)
      m_s <= rnd(m_s, int'(round_ctr) + 12 - int'(num_rounds));
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ld_rnd_excl", 64'(load_val & rounds_enable), 64'h0);
      if (done) n_done++;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 64'h1, 64'h0);
        end else begin
          chk("digest", bus.out_data, sb[0].w);
          chk("out_last", 64'(bus.out_last), 64'(sb[0].l));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic ref_push(input logic [63:0] wds[$], input int nb);
    st_t s;
    int n;
    logic [63:0] lw;
    s = '0;
    s[0] = 64'h0000080100CC0002;
    s = p12(s);
    n = (nb > 8) ? 8 : nb;
    for (int i = 0; i < wds.size() - 1; i++) begin
      s[0] ^= wds[i];
      s = p12(s);
    end
    lw = wds[wds.size() - 1];
    if (n == 8) begin
      s[0] ^= lw; s = p12(s);
      s[0] ^= 64'h1; s = p12(s);
    end else begin
      s[0] ^= pad_ref(lw, n); s = p12(s);
    end
    for (int j = 0; j < 4; j++) begin
      sb.push_back('{w: s[0], l: (j == 3)});
      if (j < 3) s = p12(s);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_msg(input logic [63:0] wds[$], input int nb,
                          output int t_hs);
    int t;
    int n;
    logic lst;
    logic [63:0] eb;
    t_hs = 0;
    n = (nb > 8) ? 8 : nb;
    for (int i = 0; i < wds.size(); i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      lst = (i == wds.size() - 1);
      bus.in_data  = wds[i];
      bus.in_last  = lst;
      bus.in_bytes = lst ? 4'(nb) : 4'd8;
      bus.in_valid = 1'b1;
      eb = (lst && n < 8) ? pad_ref(wds[i], n) : wds[i];
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.in_ready && t < 200);
      chk("in_ready", 64'(bus.in_ready), 64'h1);
      chk("abs_load", 64'(load_val), 64'h1);
      chk("abs_blk", ld0 ^ m_s[0], eb);
      t_hs = cyc;
      @(posedge clk); #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output int t_o);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.out_valid && t < 200);
    chk("out_valid", 64'(bus.out_valid), 64'h1);
    t_o = cyc;
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'h0);
    chk("idle", 64'(busy), 64'h0);
    chk("done_cnt", 64'(n_done - d0), 64'h1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_inrdy"}, 64'(bus.in_ready), 64'h0);
    chk({tag, "_oval"}, 64'(bus.out_valid), 64'h0);
    chk({tag, "_olast"}, 64'(bus.out_last), 64'h0);
    chk({tag, "_odata"}, bus.out_data, 64'h0);
    chk({tag, "_ld"}, 64'(load_val), 64'h0);
    chk({tag, "_ren"}, 64'(rounds_enable), 64'h0);
    chk({tag, "_ctr"}, 64'(round_ctr), 64'h0);
    chk({tag, "_nr"}, 64'(num_rounds), 64'd12);
    chk({tag, "_done"}, 64'(done), 64'h0);
    chk({tag, "_s0"}, ld0, 64'h0);
  endtask

  initial begin
    int t_in, t_o, d0, t;
    logic [63:0] q[$];
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bytes  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 chk_reset_outs("rst");
    rst_n = 1'b1;

    // start timing, then empty message
    do_start();
    @(negedge clk);
    chk("init_ld", 64'(load_val), 64'h1);
    chk("init_iv", ld0, 64'h0000080100CC0002);
    chk("init_s1", ld1 | ld2 | ld3 | ld4, 64'h0);
    chk("init_busy", 64'(busy), 64'h1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("perm_en", 64'(rounds_enable), 64'h1);
      chk("perm_ctr", 64'(round_ctr), 64'(i));
    end
    @(negedge clk);
    chk("first_rdy", 64'(bus.in_ready), 64'h1);
    q = '{64'hDEADBEEF_CAFEF00D};
    ref_push(q, 0);
    d0 = n_done;
    send_msg(q, 0, t_in);
    wait_done(d0);

    // full 8-byte word: PAD path and latency
    do_start();
    q = '{64'h0706050403020100};
    ref_push(q, 8);
    d0 = n_done;
    send_msg(q, 8, t_in);
    do @(negedge clk); while (cyc < t_in + 13);
    chk("pad_ld", 64'(load_val), 64'h1);
    chk("pad_xor", ld0 ^ m_s[0], 64'h1);
    wait_out(t_o);
    chk("lat8", 64'(t_o - t_in), 64'd26);
    wait_done(d0);

    // 3 bytes with upper garbage, back-pressure on word 2
    bus.out_ready = 1'b0;
    do_start();
    q = '{64'hA5A5A5A5A5020100};
    ref_push(q, 3);
    d0 = n_done;
    send_msg(q, 3, t_in);
    wait_out(t_o);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    wait_out(t_o);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 64'h1);
      chk("bp_data", bus.out_data, sb[0].w);
      chk("bp_ctr", 64'(round_ctr), 64'h0);
      chk("bp_last", 64'(bus.out_last), 64'h0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_done(d0);

    // multi-word, in_bytes=12 acts as 8
    do_start();
    q = '{64'h1122334455667788, 64'h0F0E0D0C0B0A0908,
          64'hFEDCBA9876543210};
    ref_push(q, 12);
    d0 = n_done;
    send_msg(q, 12, t_in);
    wait_done(d0);

    // two words, 5-byte tail
    do_start();
    q = '{64'h0123456789ABCDEF, 64'hFFFFFF4342414039};
    ref_push(q, 5);
    d0 = n_done;
    send_msg(q, 5, t_in);
    wait_done(d0);

    // reset during PERM, then a fresh hash
    do_start();
    t = 0;
    while (!(rounds_enable && round_ctr == 4'd5) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("mid_ctr5", 64'(round_ctr), 64'd5);
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("mid");
    sb.delete();
    @(posedge clk); #1 chk_reset_outs("mid2");
    @(negedge clk) rst_n = 1'b1;
    do_start();
    q = '{64'h00DDCCBBAA998877};
    ref_push(q, 7);
    d0 = n_done;
    send_msg(q, 7, t_in);
    wait_done(d0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
